// File: rtl/vga_pixel_capture.sv
// vga_pixel_capture: recovers pixel/line position from an active-low HS/VS
// video stream and extracts a COLS x ROWS grayscale window.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   R, G, B           : 8-bit colour channels
//   HS, VS            : active-low horizontal / vertical sync
//   pix_out           : grayscale (R + 2G + B) >> 2, held while pix_valid=0
//   pix_valid         : pix_out / pix_x / pix_y valid this cycle
//   pix_x, pix_y      : column 0..COLS-1 / row 0..ROWS-1
//   sof, eol          : first pixel of frame / last pixel of line
//   frame_done        : one-cycle pulse after the last pixel of a frame
//   sync_err          : sticky sync fault flag, cleared only by rst
module vga_pixel_capture #(
    parameter int unsigned H_BP = 88,
    parameter int unsigned V_BP = 23,
    parameter int unsigned COLS = 512,
    parameter int unsigned ROWS = 512,
    parameter int unsigned CW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    R,
    input  logic [7:0]    G,
    input  logic [7:0]    B,
    input  logic          HS,
    input  logic          VS,
    output logic [7:0]    pix_out,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          sof,
    output logic          eol,
    output logic          frame_done,
    output logic          sync_err
);

    localparam int unsigned HW = $clog2(H_BP) + 1;
    localparam int unsigned PW = $clog2(V_BP + 1) + 1;

    typedef enum logic [1:0] {V_WAIT, V_PORCH, V_ACTIVE} v_state_t;
    typedef enum logic [1:0] {H_WAIT, H_PORCH, H_ACTIVE} h_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
    } vid_t;

    // Input stage: colour needs one stage here (the pix_out register is its
    // second); the sync bits get a second stage for edge detection.
    vid_t s1;
    logic hs_s2, vs_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '{8'd0, 8'd0, 8'd0, 1'b1, 1'b1};
            hs_s2 <= 1'b1;
            vs_s2 <= 1'b1;
        end else begin
            s1    <= '{R, G, B, HS, VS};
            hs_s2 <= s1.hs;
            vs_s2 <= s1.vs;
        end
    end

    logic hs_rise, hs_fall, vs_rise, vs_fall;
    assign hs_rise = s1.hs & ~hs_s2;
    assign hs_fall = ~s1.hs & hs_s2;
    assign vs_rise = s1.vs & ~vs_s2;
    assign vs_fall = ~s1.vs & vs_s2;

    logic [7:0] gray_c;
    assign gray_c = 8'((10'(s1.r) + 10'({s1.g, 1'b0}) + 10'(s1.b)) >> 2);

    v_state_t      v_st, v_nxt;
    h_state_t      h_st, h_nxt;
    logic [PW-1:0] porch_q, porch_nxt;
    logic [HW-1:0] hcnt_q, hcnt_nxt;
    logic [CW-1:0] x_q, x_nxt, row_q, row_nxt;
    logic          emit_c, err_c, line_start_c;

    // A line starts on the hs_rise that ends the vertical porch, or on any
    // later hs_rise while rows remain in the frame.
    assign line_start_c = hs_rise && !vs_fall && (h_st == H_WAIT) &&
                          (((v_st == V_PORCH) && (porch_q == PW'(V_BP))) ||
                           ((v_st == V_ACTIVE) && (row_q != CW'(ROWS - 1))));

    logic [7:0]    pix_out_d;
    logic          pix_valid_d, sof_d, eol_d, frame_done_d, sync_err_d;
    logic [CW-1:0] pix_x_d, pix_y_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v_st       <= V_WAIT;
            h_st       <= H_WAIT;
            porch_q    <= '0;
            hcnt_q     <= '0;
            x_q        <= '0;
            row_q      <= '0;
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            v_st       <= v_nxt;
            h_st       <= h_nxt;
            porch_q    <= porch_nxt;
            hcnt_q     <= hcnt_nxt;
            x_q        <= x_nxt;
            row_q      <= row_nxt;
            pix_out    <= pix_out_d;
            pix_valid  <= pix_valid_d;
            pix_x      <= pix_x_d;
            pix_y      <= pix_y_d;
            sof        <= sof_d;
            eol        <= eol_d;
            frame_done <= frame_done_d;
            sync_err   <= sync_err_d;
        end
    end

    // Next-state logic for the horizontal and vertical FSMs
    always_comb begin
        v_nxt     = v_st;
        h_nxt     = h_st;
        porch_nxt = porch_q;
        hcnt_nxt  = hcnt_q;
        x_nxt     = x_q;
        row_nxt   = row_q;
        emit_c    = 1'b0;
        err_c     = 1'b0;

        case (h_st)
            H_WAIT: begin
                // Porch is H_BP-2 countdown cycles: one cycle is spent in
                // H_WAIT on the edge and one in the final zero count.
                if (line_start_c) begin
                    h_nxt    = H_PORCH;
                    hcnt_nxt = HW'(H_BP - 2);
                end
            end
            H_PORCH: begin
                if (hs_fall) begin
                    h_nxt = H_WAIT;
                    err_c = 1'b1;
                end else if (hcnt_q == '0) begin
                    h_nxt = H_ACTIVE;
                    x_nxt = '0;
                end else begin
                    hcnt_nxt = hcnt_q - 1'b1;
                end
            end
            H_ACTIVE: begin
                if (hs_fall) begin
                    h_nxt = H_WAIT;
                    err_c = 1'b1;
                end else begin
                    emit_c = 1'b1;
                    if (x_q == CW'(COLS - 1)) begin
                        h_nxt = H_WAIT;
                        if (row_q == CW'(ROWS - 1)) v_nxt = V_WAIT;
                    end else begin
                        x_nxt = x_q + 1'b1;
                    end
                end
            end
            default: h_nxt = H_WAIT;
        endcase

        case (v_st)
            V_WAIT: begin
                // A coincident hs_rise counts as the first porch edge.
                if (vs_rise) begin
                    v_nxt     = V_PORCH;
                    row_nxt   = '0;
                    porch_nxt = hs_rise ? PW'(1) : PW'(0);
                end
            end
            V_PORCH: begin
                if (vs_fall) begin
                    v_nxt = V_WAIT;
                    err_c = 1'b1;
                end else if (hs_rise) begin
                    if (porch_q == PW'(V_BP)) begin
                        v_nxt   = V_ACTIVE;
                        row_nxt = '0;
                    end else begin
                        porch_nxt = porch_q + 1'b1;
                    end
                end
            end
            V_ACTIVE: begin
                // vs_fall abandons the frame, overriding any pixel in flight.
                if (vs_fall) begin
                    v_nxt  = V_WAIT;
                    h_nxt  = H_WAIT;
                    emit_c = 1'b0;
                    err_c  = 1'b1;
                end else if (line_start_c) begin
                    row_nxt = row_q + 1'b1;
                end
            end
            default: v_nxt = V_WAIT;
        endcase
    end

    // Output next-values
    always_comb begin
        pix_valid_d  = emit_c;
        pix_out_d    = pix_out;
        pix_x_d      = pix_x;
        pix_y_d      = pix_y;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        frame_done_d = pix_valid && eol && (pix_y == CW'(ROWS - 1));
        sync_err_d   = sync_err | err_c;
        if (emit_c) begin
            pix_out_d = gray_c;
            pix_x_d   = x_q;
            pix_y_d   = row_q;
            sof_d     = (x_q == '0) && (row_q == '0);
            eol_d     = (x_q == CW'(COLS - 1));
        end
    end

endmodule
